dmem_access_arbiter: RTL and testbench
======================================

Name: dmem_access_arbiter

Overview:
- Sequences the single-ported data memory and shares it between two requesters: the pipeline MEM stage and a DMA/debug loader port.
- The memory has a fixed multi-cycle latency, so the block holds one access in flight and stalls the pipeline until that access completes.
- Sits between the MEM stage and the data memory. It drives the memory's read, write, load-mode, address and write-data inputs and returns the read word to the owning requester.

Parameters:
- MEM_LATENCY, 2, cycles the memory controls must be held per access (>=1)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- pipe_req  in  1  MEM stage access request; held until pipe_done
- pipe_we  in  1  1 = store, 0 = load
- pipe_load_mode  in  2  load/store size mode, passed to memory
- pipe_addr  in  ADDR_W  byte address
- pipe_wdata  in  DATA_W  store data
- pipe_stall  out  1  freeze pipeline stages up to MEM
- pipe_done  out  1  one-cycle completion pulse to MEM stage
- dma_req  in  1  DMA access request; held until dma_done
- dma_we  in  1  1 = write, 0 = read
- dma_load_mode  in  2  size mode
- dma_addr  in  ADDR_W  byte address
- dma_wdata  in  DATA_W  write data
- dma_done  out  1  one-cycle completion pulse to DMA
- rdata  out  DATA_W  read word of last completed load; valid with the done pulse
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_load_mode  out  2  memory size mode
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, BUSY, RESP.
  - Requests are sampled only in IDLE.
  - RESP is a guard cycle: a requester still asserting req during its done cycle is not re-accepted.
- IDLE:
  - No request: stay in IDLE.
  - Requests present: select an owner, latch that owner's we, load_mode, addr and wdata into registers, load cnt = MEM_LATENCY-1, go to BUSY.
- Arbitration:
  - A single requester wins.
  - When both request, the grant goes to the requester that is not last_owner (round-robin).
  - last_owner updates at each grant.
  - last_owner resets to DMA, so the pipeline wins the first tie.
- BUSY:
  - mem_read = ~we_q and mem_write = we_q, driven from registers.
  - mem_addr, mem_wdata and mem_load_mode come from the latched fields and are stable for all MEM_LATENCY cycles.
  - cnt decrements each cycle.
  - At cnt==0: if the access is a load, capture mem_rdata into rdata; go to RESP.
- RESP:
  - The owner's done is high for exactly this cycle.
  - Memory enables are low.
  - Next state is IDLE.
- Latency:
  - Request accepted at the end of cycle N.
  - Memory enables are high in cycles N+1..N+MEM_LATENCY.
  - done is high in cycle N+MEM_LATENCY+1.
  - Peak throughput is one access per MEM_LATENCY+2 cycles.
- pipe_stall = pipe_req & ~pipe_done (combinational). It is high while the pipeline waits, including while the DMA owns the memory.
- Stores: rdata is unchanged; done still pulses.
- Outside BUSY: mem_read and mem_write are 0; mem_addr, mem_wdata and mem_load_mode hold their last latched values.
- Requester behaviour:
  - A requester withdrawing req before done is a protocol violation; the access completes anyway.
  - Changing address or data while req is held has no effect after acceptance.
- Reset (including mid-access):
  - State goes to IDLE, cnt = 0, last_owner = DMA.
  - rdata = 0, latched fields = 0, all done signals = 0, mem_read = mem_write = 0.
  - An in-flight access is abandoned, and no done pulse is issued for it.

Decomposition:
- Shared package (mips_mem_pkg):
  - state encoding for IDLE/BUSY/RESP
  - owner encoding: OWN_PIPE = 0, OWN_DMA = 1
  - load_mode constants: word, half, byte
- No sub-module needed. Optional: factor the round-robin selector as rr_arb2, a 2-input arbiter holding the last_owner register.

Test Plan:
- Pipe load, MEM_LATENCY = 2: pipe_req at cycle 0, addr 0x10, mem_rdata = 0xDEADBEEF → mem_read high in cycles 1-2; pipe_done and rdata = 0xDEADBEEF in cycle 3; pipe_stall high in cycles 0-2, low in cycle 3.
- DMA store: dma_req, addr 0x20, wdata 0x12345678, mode 2'b00 → mem_write high for 2 cycles with stable addr, data and mode; dma_done in cycle 3; rdata unchanged.
- Simultaneous requests from reset → pipe is served first (done at cycle 3), then DMA (accepted cycle 4, done at cycle 7). Repeat the tie → DMA served first on alternate ties.
- Held request through RESP: pipe_req stays high one extra cycle after pipe_done → no second access starts; mem_read stays low.
- DMA owns the memory when pipe_req rises at cycle 2 → pipe_stall is high until pipe_done, which occurs 4 cycles after the DMA completes.
- Reset asserted in the second BUSY cycle → next cycle: mem_read = 0, no done pulse, rdata = 0; a new request afterwards completes normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the data-memory access path: FSM states, owner ids, size modes.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic OWN_PIPE = 1'b0;
  localparam logic OWN_DMA  = 1'b1;

  localparam logic [1:0] LM_WORD = 2'b00;
  localparam logic [1:0] LM_HALF = 2'b01;
  localparam logic [1:0] LM_BYTE = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector between the MEM stage and the DMA port.
// The last_owner register only moves when the grant is actually taken.
module rr_arb2
  import mips_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_pipe,
  input  logic req_dma,
  input  logic accept,
  output logic owner
);

  logic last_owner_q;

  // Single requester wins outright; on a tie the one that did not go last wins.
  always_comb begin
    owner = OWN_DMA;
    if (req_pipe && req_dma) begin
      owner = (last_owner_q == OWN_DMA) ? OWN_PIPE : OWN_DMA;
    end else if (req_pipe) begin
      owner = OWN_PIPE;
    end
  end

  // Reset to DMA so the pipeline wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= OWN_DMA;
    end else if (accept) begin
      last_owner_q <= owner;
    end
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Sequences the single-ported data memory between the MEM stage and a DMA/debug port.
// One access is in flight at a time; the memory controls are held for MEM_LATENCY cycles.
module dmem_access_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  // MEM stage
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [1:0]        pipe_load_mode,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_stall,
  output logic              pipe_done,
  // DMA / debug loader
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [1:0]        dma_load_mode,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_done,
  // Shared read return
  output logic [DATA_W-1:0] rdata,
  // Data memory
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_load_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned    CntW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic any_req;
  logic accept;
  logic grant_owner;

  assign any_req = pipe_req | dma_req;
  assign accept  = (state_q == StIdle) && any_req;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .req_pipe (pipe_req),
    .req_dma  (dma_req),
    .accept   (accept),
    .owner    (grant_owner)
  );

  // State and latched access fields; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      owner_q <= OWN_PIPE;
      we_q    <= 1'b0;
      mode_q  <= LM_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state: accept in IDLE, count down in BUSY, one guard/response cycle in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d = grant_owner;
          if (grant_owner == OWN_PIPE) begin
            we_d    = pipe_we;
            mode_d  = pipe_load_mode;
            addr_d  = pipe_addr;
            wdata_d = pipe_wdata;
          end else begin
            we_d    = dma_we;
            mode_d  = dma_load_mode;
            addr_d  = dma_addr;
            wdata_d = dma_wdata;
          end
          cnt_d   = CntLoad;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          // Memory data is valid in the last held cycle.
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from registers only, so the memory sees glitch-free controls.
  always_comb begin
    mem_read  = (state_q == StBusy) && !we_q;
    mem_write = (state_q == StBusy) && we_q;
    pipe_done = (state_q == StResp) && (owner_q == OWN_PIPE);
    dma_done  = (state_q == StResp) && (owner_q == OWN_DMA);
  end

  assign mem_load_mode = mode_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign rdata         = rdata_q;

  // Pipeline waits whenever it is asking and not being answered this cycle.
  assign pipe_stall = pipe_req & ~pipe_done;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Self-checking bench for dmem_access_arbiter with an in-order scoreboard of accesses.
module tb_dmem_access_arbiter;
  import mips_mem_pkg::*;

  localparam int unsigned LAT = 2;

  logic        clk;
  logic        rst;
  logic        pipe_req, pipe_we, dma_req, dma_we;
  logic [1:0]  pipe_load_mode, dma_load_mode, mem_load_mode;
  logic [31:0] pipe_addr, pipe_wdata, dma_addr, dma_wdata;
  logic        pipe_stall, pipe_done, dma_done;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  typedef struct {
    logic        owner;
    logic        we;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          en_cnt = 0;
  logic [31:0] rd_model = '0;
  logic        lo_model = OWN_DMA;

  dmem_access_arbiter #(
    .MEM_LATENCY (LAT),
    .ADDR_W      (32),
    .DATA_W      (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pipe_req       (pipe_req),
    .pipe_we        (pipe_we),
    .pipe_load_mode (pipe_load_mode),
    .pipe_addr      (pipe_addr),
    .pipe_wdata     (pipe_wdata),
    .pipe_stall     (pipe_stall),
    .pipe_done      (pipe_done),
    .dma_req        (dma_req),
    .dma_we         (dma_we),
    .dma_load_mode  (dma_load_mode),
    .dma_addr       (dma_addr),
    .dma_wdata      (dma_wdata),
    .dma_done       (dma_done),
    .rdata          (rdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_load_mode  (mem_load_mode),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  function automatic logic done_of(input logic own);
    return own ? dma_done : pipe_done;
  endfunction

  function automatic void push(input logic own, input logic we, input logic [1:0] mode,
                               input logic [31:0] addr, input logic [31:0] wdata);
    acc_t e;
    e.owner = own; e.we = we; e.mode = mode; e.addr = addr; e.wdata = wdata;
    sb_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic req, input logic we, input logic [1:0] mode,
                          input logic [31:0] addr, input logic [31:0] wdata);
    pipe_req = req; pipe_we = we; pipe_load_mode = mode; pipe_addr = addr; pipe_wdata = wdata;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [1:0] mode,
                         input logic [31:0] addr, input logic [31:0] wdata);
    dma_req = req; dma_we = we; dma_load_mode = mode; dma_addr = addr; dma_wdata = wdata;
  endtask

  // Scoreboard: memory controls must match the front access; done pops and checks it.
  always @(negedge clk) begin
    if (mem_read === 1'b1 || mem_write === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mem_access read=%0b write=%0b addr=%h", mem_read, mem_write,
                 mem_addr);
      end else if (mem_read !== !sb_q[0].we || mem_write !== sb_q[0].we ||
                   mem_addr !== sb_q[0].addr || mem_wdata !== sb_q[0].wdata ||
                   mem_load_mode !== sb_q[0].mode) begin
        errors++;
        $display("FAIL mem_ctrl got rd=%0b wr=%0b a=%h d=%h m=%0d exp we=%0b a=%h d=%h m=%0d",
                 mem_read, mem_write, mem_addr, mem_wdata, mem_load_mode, sb_q[0].we,
                 sb_q[0].addr, sb_q[0].wdata, sb_q[0].mode);
      end
      en_cnt++;
    end
    if (pipe_done === 1'b1 || dma_done === 1'b1) begin
      acc_t e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done pipe=%0b dma=%0b exp none", pipe_done, dma_done);
      end else begin
        e = sb_q.pop_front();
        if (!e.we) rd_model = mem_fn(e.addr);
        if (pipe_done !== (e.owner == OWN_PIPE) || dma_done !== (e.owner == OWN_DMA)) begin
          errors++;
          $display("FAIL done_owner got pipe=%0b dma=%0b exp owner=%0b", pipe_done, dma_done,
                   e.owner);
        end
        checks++;
        if (rdata !== rd_model) begin
          errors++;
          $display("FAIL done_rdata got=%h exp=%h", rdata, rd_model);
        end
        checks++;
        if (en_cnt != LAT) begin
          errors++;
          $display("FAIL enable_cycles got=%0d exp=%0d", en_cnt, LAT);
        end
      end
      en_cnt = 0;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb_q.delete();
    rd_model = '0;
    lo_model = OWN_DMA;
    en_cnt   = 0;
  endtask

  // Plain access that relies on the scoreboard; bounded wait for done.
  task automatic quick_access(input logic own, input logic we, input logic [1:0] mode,
                              input logic [31:0] addr, input logic [31:0] wdata);
    int  cyc  = 0;
    bit  seen = 0;
    push(own, we, mode, addr, wdata);
    lo_model = own;
    if (own == OWN_PIPE) set_pipe(1'b1, we, mode, addr, wdata);
    else set_dma(1'b1, we, mode, addr, wdata);
    while (!seen && cyc < 20) begin
      @(negedge clk);
      if (done_of(own) === 1'b1) seen = 1;
      tick();
      cyc++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL quick_access_timeout got=no_done exp=done owner=%0b", own);
    end
    if (own == OWN_PIPE) pipe_req = 1'b0;
    else dma_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_enables got rd=%0b wr=%0b exp 0 0", mem_read, mem_write);
    end
    checks++;
    if (pipe_done !== 1'b0 || dma_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got pipe=%0b dma=%0b exp 0 0", pipe_done, dma_done);
    end
    checks++;
    if (rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_load_mode !== 2'b0)
    begin
      errors++;
      $display("FAIL reset_regs got rdata=%h addr=%h wdata=%h mode=%0d exp zeros", rdata,
               mem_addr, mem_wdata, mem_load_mode);
    end
    checks++;
    if (pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got=%0b exp=0", pipe_stall);
    end
    tick();
  endtask

  task automatic test_pipe_load();
    push(OWN_PIPE, 1'b0, LM_WORD, 32'h10, 32'h0);
    lo_model = OWN_PIPE;
    set_pipe(1'b1, 1'b0, LM_WORD, 32'h10, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (mem_read !== (c == 1 || c == 2)) begin
        errors++;
        $display("FAIL pipe_load_read c%0d got=%0b exp=%0b", c, mem_read, (c == 1 || c == 2));
      end
      checks++;
      if (pipe_stall !== (c < 3)) begin
        errors++;
        $display("FAIL pipe_load_stall c%0d got=%0b exp=%0b", c, pipe_stall, (c < 3));
      end
      checks++;
      if (pipe_done !== (c == 3)) begin
        errors++;
        $display("FAIL pipe_load_done c%0d got=%0b exp=%0b", c, pipe_done, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
          errors++;
          $display("FAIL pipe_load_rdata got=%h exp=deadbeef", rdata);
        end
      end
      tick();
    end
    pipe_req = 1'b0;
  endtask

  task automatic test_dma_store();
    push(OWN_DMA, 1'b1, 2'b00, 32'h20, 32'h1234_5678);
    lo_model = OWN_DMA;
    set_dma(1'b1, 1'b1, 2'b00, 32'h20, 32'h1234_5678);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (mem_write !== (c == 1 || c == 2) || mem_read !== 1'b0) begin
        errors++;
        $display("FAIL dma_store_write c%0d got wr=%0b rd=%0b", c, mem_write, mem_read);
      end
      checks++;
      if (dma_done !== (c == 3)) begin
        errors++;
        $display("FAIL dma_store_done c%0d got=%0b exp=%0b", c, dma_done, (c == 3));
      end
      tick();
      // Data changes after acceptance must not reach the memory.
      if (c == 0) dma_wdata = 32'hFFFF_0000;
    end
    dma_req = 1'b0;
    checks++;
    if (rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL dma_store_rdata_kept got=%h exp=deadbeef", rdata);
    end
  endtask

  task automatic test_held_req();
    push(OWN_PIPE, 1'b1, LM_BYTE, 32'h30, 32'h0000_00AB);
    lo_model = OWN_PIPE;
    set_pipe(1'b1, 1'b1, LM_BYTE, 32'h30, 32'h0000_00AB);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        checks++;
        if (pipe_done !== (c == 3) || mem_read !== 1'b0 || mem_write !== 1'b0) begin
          errors++;
          $display("FAIL held_req c%0d got done=%0b rd=%0b wr=%0b exp done=%0b rd=0 wr=0", c,
                   pipe_done, mem_read, mem_write, (c == 3));
        end
      end
      tick();
      if (c == 3) pipe_req = 1'b0;
    end
  endtask

  task automatic run_tie(input logic [31:0] pa, input logic [31:0] da, input string name);
    logic w;
    logic l;
    w = (lo_model == OWN_DMA) ? OWN_PIPE : OWN_DMA;
    l = ~w;
    if (w == OWN_PIPE) begin
      push(OWN_PIPE, 1'b0, LM_WORD, pa, 32'h0);
      push(OWN_DMA, 1'b1, LM_HALF, da, ~da);
    end else begin
      push(OWN_DMA, 1'b1, LM_HALF, da, ~da);
      push(OWN_PIPE, 1'b0, LM_WORD, pa, 32'h0);
    end
    set_pipe(1'b1, 1'b0, LM_WORD, pa, 32'h0);
    set_dma(1'b1, 1'b1, LM_HALF, da, ~da);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (done_of(w) !== (c == 3)) begin
        errors++;
        $display("FAIL %s_winner_done c%0d got=%0b exp=%0b owner=%0b", name, c, done_of(w),
                 (c == 3), w);
      end
      checks++;
      if (done_of(l) !== (c == 7)) begin
        errors++;
        $display("FAIL %s_loser_done c%0d got=%0b exp=%0b owner=%0b", name, c, done_of(l),
                 (c == 7), l);
      end
      tick();
      if (c == 3) begin
        if (w == OWN_PIPE) pipe_req = 1'b0;
        else dma_req = 1'b0;
      end
    end
    pipe_req = 1'b0;
    dma_req  = 1'b0;
    lo_model = l;
  endtask

  task automatic test_round_robin();
    do_reset();
    run_tie(32'h40, 32'h50, "tie1");
    quick_access(OWN_PIPE, 1'b0, LM_WORD, 32'h44, 32'h0);
    run_tie(32'h48, 32'h58, "tie2");
  endtask

  task automatic test_dma_then_pipe();
    push(OWN_DMA, 1'b0, LM_WORD, 32'h60, 32'h0);
    push(OWN_PIPE, 1'b0, LM_HALF, 32'h70, 32'h0);
    set_dma(1'b1, 1'b0, LM_WORD, 32'h60, 32'h0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (pipe_stall !== (c >= 2 && c < 7)) begin
        errors++;
        $display("FAIL wait_stall c%0d got=%0b exp=%0b", c, pipe_stall, (c >= 2 && c < 7));
      end
      checks++;
      if (dma_done !== (c == 3) || pipe_done !== (c == 7)) begin
        errors++;
        $display("FAIL wait_done c%0d got dma=%0b pipe=%0b exp dma=%0b pipe=%0b", c, dma_done,
                 pipe_done, (c == 3), (c == 7));
      end
      tick();
      if (c == 1) set_pipe(1'b1, 1'b0, LM_HALF, 32'h70, 32'h0);
      if (c == 3) dma_req = 1'b0;
    end
    pipe_req = 1'b0;
    lo_model = OWN_PIPE;
  endtask

  task automatic test_reset_mid();
    quick_access(OWN_PIPE, 1'b0, LM_WORD, 32'h10, 32'h0);
    push(OWN_PIPE, 1'b0, LM_WORD, 32'h80, 32'h0);
    lo_model = OWN_PIPE;
    set_pipe(1'b1, 1'b0, LM_WORD, 32'h80, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    pipe_req = 1'b0;
    sb_q.delete();
    rd_model = '0;
    lo_model = OWN_DMA;
    en_cnt   = 0;
    for (int c = 3; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (mem_read !== 1'b0 || pipe_done !== 1'b0 || dma_done !== 1'b0 || rdata !== 32'h0)
      begin
        errors++;
        $display("FAIL reset_mid c%0d got rd=%0b pdone=%0b ddone=%0b rdata=%h exp 0 0 0 0", c,
                 mem_read, pipe_done, dma_done, rdata);
      end
      tick();
    end
    run_tie(32'h90, 32'hA0, "after_reset");
  endtask

  initial begin
    rst = 1'b1;
    set_pipe(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    test_reset();
    test_pipe_load();
    test_dma_store();
    test_held_req();
    test_round_robin();
    test_dma_then_pipe();
    test_reset_mid();
    tick();
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained got=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
